pipe_stage_skid: RTL and testbench

//  Parametrised inter-stage pipeline register with a valid/ready handshake and a 2-entry skid buffer.

---
 rtl/pipe_stage_skid_if.sv | 26 ++
 rtl/pipe_stage_skid.sv | 148 ++++++++++++++
 tb/tb_pipe_stage_skid.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready payload channel between two pipeline stages.
// The producer side uses modport master; the consumer side uses modport slave.
// W sets the payload width and must match the attached stage's PAYLOAD_W.
interface pipe_stage_skid_if #(
  parameter int W = 75
) ();

  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  // Producer drives valid and data, and observes ready.
  modport master (
    output valid,
    output data,
    input  ready
  );

  // Consumer observes valid and data, and drives ready.
  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/pipe_stage_skid.sv
// Purpose: inter-stage pipeline register with a valid/ready handshake, a 2-entry skid buffer and a sync flush.
// Latency: 1 falling edge from in to out; full throughput when downstream is ready.
// Backpressure: in_ready (up.ready) is a pure decode of state, so it never depends combinationally on out_ready.
// Optional: defining PIPE_STAGE_BUBBLE_CNT_EN adds the bubble_cnt port and a saturating bubble counter.
module pipe_stage_skid #(
  parameter int PAYLOAD_W  = 75,
  parameter bit CLEAR_DATA = 1'b1
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
  ,
  parameter int CNT_W      = 16
`endif
) (
  input  logic                 CLK,
  input  logic                 Resetn,
  input  logic                 flush,
  pipe_stage_skid_if.slave     up,
  pipe_stage_skid_if.master    dn,
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
  output logic [CNT_W-1:0]     bubble_cnt,
`endif
  output logic [1:0]           occupancy
);

  // State encoding equals the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_nxt;

  // M is the head entry and drives out_data; S catches the beat that arrives while the head is stalled.
  logic [PAYLOAD_W-1:0] m_q;
  logic [PAYLOAD_W-1:0] s_q;

  logic                 in_rdy;
  logic                 out_vld;
  logic                 out_rdy;
  logic                 in_vld;
  logic [PAYLOAD_W-1:0] in_data;
  logic [PAYLOAD_W-1:0] out_data;
  logic                 push;
  logic                 pop;

  assign in_vld   = up.valid;
  assign in_data  = up.data;
  assign out_rdy  = dn.ready;
  assign up.ready = in_rdy;
  assign dn.valid = out_vld;
  assign dn.data  = out_data;

  // A handshake happens only where both sides agree. A stray in_valid while full, or out_ready while empty, does nothing.
  assign push = in_vld & in_rdy;
  assign pop  = out_vld & out_rdy;

  // State register. All pipeline state moves on the falling edge.
  always_ff @(negedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic. A flush squashes everything, including a push on the same edge.
  always_comb begin
    state_nxt = state_q;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (push) state_nxt = ST_ONE;
        ST_ONE: begin
          if (push && !pop)      state_nxt = ST_FULL;
          else if (!push && pop) state_nxt = ST_EMPTY;
          else                   state_nxt = ST_ONE;
        end
        // FULL cannot push (in_ready is low), so only a pop moves it.
        ST_FULL:  if (pop) state_nxt = ST_ONE;
        default:  state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Output decode. Both flags come straight from the state register.
  always_comb begin
    occupancy = state_q;
    in_rdy    = (state_q != ST_FULL);
    out_vld   = (state_q != ST_EMPTY);
    out_data  = m_q;
    // Bubbles present all-zero payload, so a stray RegWr cannot leak downstream.
    if (CLEAR_DATA && !out_vld) begin
      out_data = '0;
    end
  end

  // Payload registers. They follow the same transitions as the FSM, so ordering stays strictly FIFO.
  always_ff @(negedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      m_q <= '0;
      s_q <= '0;
    end else if (flush) begin
      if (CLEAR_DATA) begin
        m_q <= '0;
        s_q <= '0;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) m_q <= in_data;
        end
        ST_ONE: begin
          if (push && pop) begin
            m_q <= in_data;
          end else if (push) begin
            s_q <= in_data;
          end else if (pop && CLEAR_DATA) begin
            m_q <= '0;
            s_q <= '0;
          end
        end
        ST_FULL: begin
          if (pop) begin
            m_q <= s_q;
            if (CLEAR_DATA) s_q <= '0;
          end
        end
        default: begin
          m_q <= m_q;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_BUBBLE_CNT_EN
  // Count edges where downstream was ready but starved. The count saturates, and only reset clears it.
  always_ff @(negedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      bubble_cnt <= '0;
    end else if (!out_vld && out_rdy && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed testbench for pipe_stage_skid.
// It drives inputs just after each falling edge and checks outputs 1 time unit after the next falling edge.
// The bubble-counter steps are included only when PIPE_STAGE_BUBBLE_CNT_EN is defined.
module tb_pipe_stage_skid;

  localparam int W = 75;

  logic CLK;
  logic Resetn;
  logic flush;
  logic [1:0] occupancy;

  pipe_stage_skid_if #(.W(W)) up_if ();
  pipe_stage_skid_if #(.W(W)) dn_if ();

  int checks;
  int errors;

`ifdef PIPE_STAGE_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt;
  logic        s_flush;
  logic [1:0]  s_occ;
  logic [1:0]  s_bubble;

  pipe_stage_skid_if #(.W(8)) s_up ();
  pipe_stage_skid_if #(.W(8)) s_dn ();

  pipe_stage_skid #(.PAYLOAD_W(W), .CLEAR_DATA(1'b1), .CNT_W(16)) u_dut (
    .CLK(CLK), .Resetn(Resetn), .flush(flush), .up(up_if), .dn(dn_if),
    .bubble_cnt(bubble_cnt), .occupancy(occupancy)
  );

  // This small instance sits permanently idle, so its 2-bit counter should saturate.
  pipe_stage_skid #(.PAYLOAD_W(8), .CLEAR_DATA(1'b1), .CNT_W(2)) u_sat (
    .CLK(CLK), .Resetn(Resetn), .flush(s_flush), .up(s_up), .dn(s_dn),
    .bubble_cnt(s_bubble), .occupancy(s_occ)
  );

  assign s_flush    = 1'b0;
  assign s_up.valid = 1'b0;
  assign s_up.data  = 8'h00;
  assign s_dn.ready = 1'b1;
`else
  pipe_stage_skid #(.PAYLOAD_W(W), .CLEAR_DATA(1'b1)) u_dut (
    .CLK(CLK), .Resetn(Resetn), .flush(flush), .up(up_if), .dn(dn_if),
    .occupancy(occupancy)
  );
`endif

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One active (falling) edge, then settle before sampling.
  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [1:0] occ, input logic rdy,
                           input logic vld, input logic [W-1:0] dat);
    chk({tag, ".occ"},  W'(occupancy),    W'(occ));
    chk({tag, ".rdy"},  W'(up_if.ready),  W'(rdy));
    chk({tag, ".vld"},  W'(dn_if.valid),  W'(vld));
    chk({tag, ".data"}, dn_if.data,       dat);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Resetn = 1'b0;
    flush  = 1'b0;
    up_if.valid = 1'b0;
    up_if.data  = '0;
    dn_if.ready = 1'b0;
    #3;
    chk_state("reset", 2'd0, 1'b1, 1'b0, '0);

    // Test 1: fill to FULL with 0xA5, then assert reset between edges.
    #4 Resetn = 1'b1;
    up_if.valid = 1'b1; up_if.data = W'(8'hA5); dn_if.ready = 1'b0;
    tick();
    chk_state("t1_one", 2'd1, 1'b1, 1'b1, W'(8'hA5));
    tick();
    chk_state("t1_full", 2'd2, 1'b0, 1'b1, W'(8'hA5));
    #2 Resetn = 1'b0;
    #1 chk_state("t1_async_rst", 2'd0, 1'b1, 1'b0, '0);
    #1 Resetn = 1'b1;
    up_if.valid = 1'b0;

    // Test 2: stream 1,2,3 with downstream always ready.
    tick();
    dn_if.ready = 1'b1; up_if.valid = 1'b1; up_if.data = W'(8'h01);
    tick();
    chk_state("t2_d1", 2'd1, 1'b1, 1'b1, W'(8'h01));
    up_if.data = W'(8'h02);
    tick();
    chk_state("t2_d2", 2'd1, 1'b1, 1'b1, W'(8'h02));
    up_if.data = W'(8'h03);
    tick();
    chk_state("t2_d3", 2'd1, 1'b1, 1'b1, W'(8'h03));
    up_if.valid = 1'b0;
    tick();
    chk_state("t2_drain", 2'd0, 1'b1, 1'b0, '0);

    // Test 3: stall with 0x10 and 0x11 held, then release and drain in order.
    dn_if.ready = 1'b0; up_if.valid = 1'b1; up_if.data = W'(8'h10);
    tick();
    chk_state("t3_one", 2'd1, 1'b1, 1'b1, W'(8'h10));
    up_if.data = W'(8'h11);
    tick();
    chk_state("t3_full", 2'd2, 1'b0, 1'b1, W'(8'h10));
    up_if.data = W'(8'h12);
    tick();
    chk_state("t3_hold", 2'd2, 1'b0, 1'b1, W'(8'h10));
    dn_if.ready = 1'b1;
    tick();
    chk_state("t3_pop1", 2'd1, 1'b1, 1'b1, W'(8'h11));
    tick();
    chk_state("t3_pop2", 2'd1, 1'b1, 1'b1, W'(8'h12));
    up_if.valid = 1'b0;
    tick();
    chk_state("t3_empty", 2'd0, 1'b1, 1'b0, '0);

    // Test 4: flush from FULL with a push pending, then flush from EMPTY while pushing.
    dn_if.ready = 1'b0; up_if.valid = 1'b1; up_if.data = W'(8'h20);
    tick();
    up_if.data = W'(8'h21);
    tick();
    chk_state("t4_full", 2'd2, 1'b0, 1'b1, W'(8'h20));
    flush = 1'b1; up_if.data = W'(8'h22);
    tick();
    chk_state("t4_flush", 2'd0, 1'b1, 1'b0, '0);
    up_if.data = W'(8'h23);
    tick();
    chk_state("t4_flush_push", 2'd0, 1'b1, 1'b0, '0);
    flush = 1'b0; up_if.valid = 1'b0; dn_if.ready = 1'b1;
    tick();
    chk_state("t4_after", 2'd0, 1'b1, 1'b0, '0);

    // Test 5: push and pop together while in ONE.
    dn_if.ready = 1'b0; up_if.valid = 1'b1; up_if.data = W'(8'h30);
    tick();
    chk_state("t5_one", 2'd1, 1'b1, 1'b1, W'(8'h30));
    up_if.data = W'(8'h31); dn_if.ready = 1'b1;
    tick();
    chk_state("t5_pushpop", 2'd1, 1'b1, 1'b1, W'(8'h31));
    up_if.valid = 1'b0;
    tick();
    chk_state("t5_empty", 2'd0, 1'b1, 1'b0, '0);

`ifdef PIPE_STAGE_BUBBLE_CNT_EN
    // Test 6: after a fresh reset, count idle edges; the 2-bit counter saturates at 3.
    Resetn = 1'b0;
    #2;
    chk("t6_rst_cnt", W'(bubble_cnt), '0);
    chk("t6_rst_sat", W'(s_bubble), '0);
    Resetn = 1'b1;
    up_if.valid = 1'b0; dn_if.ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("t6_cnt5", W'(bubble_cnt), W'(16'd5));
    tick();
    chk("t6_cnt6", W'(bubble_cnt), W'(16'd6));
    chk("t6_sat", W'(s_bubble), W'(2'd3));
    // Flush does not clear the count, and the flush bubble is itself counted.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t6_flush_cnt", W'(bubble_cnt), W'(16'd7));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
